mp_add_sequencer: RTL and testbench
===================================

Name: mp_add_sequencer

Overview:
Multi-cycle multi-precision adder/subtractor controller. It takes operands of up to 2^LEN_WIDTH-1 words as a least-significant-word-first stream and pushes one word pair per beat through a single WORD_WIDTH-bit carry-lookahead adder stage. Between beats it holds the inter-word carry in a register. The block sits between the operand buffer and the result buffer of the multi-precision adder datapath. It owns the sequencing, the carry chaining, the word counting and both stream handshakes.

Parameters:
WORD_WIDTH, 32, width of each operand and result word; also the width of the internal adder stage.
LEN_WIDTH, 8, width of the word-count field; the maximum operand length is 2^LEN_WIDTH-1 words.

Ports:
clk  input  1  single clock; everything is on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  command strobe; sampled only in IDLE.
op_sub  input  1  0 = A+B, 1 = A-B; latched when start is accepted.
num_words  input  LEN_WIDTH  operand length in words; latched when start is accepted.
busy  output  1  high whenever state is not IDLE.
done  output  1  one-cycle pulse when the operation has completed.
carry_out  output  1  final carry; for subtraction, 1 means no borrow (A>=B).
in_valid  input  1  an operand word pair is present.
in_ready  output  1  the block accepts the operand pair this cycle.
in_a  input  WORD_WIDTH  A word, least significant word first.
in_b  input  WORD_WIDTH  B word, least significant word first.
out_valid  output  1  out_sum holds a valid result word.
out_ready  input  1  the downstream side accepts the result word.
out_sum  output  WORD_WIDTH  result word.
out_last  output  1  marks the most significant (final) result word.

Behaviour:
- Reset values: busy=0, done=0, carry_out=0, in_ready=0, out_valid=0, out_sum=0, out_last=0. State goes to IDLE, the word counter clears, the carry register clears.
- States: IDLE, RUN, DONE.
- IDLE -> RUN: on start=1 with num_words!=0.
  - Latch op_sub.
  - Load the remaining-word counter with num_words.
  - Load the carry register with op_sub (carry-in is 1 for subtraction).
- start with num_words=0: ignored. The block stays in IDLE, no done pulse, carry_out unchanged.
- start in RUN or DONE: ignored.
- in_ready = (state==RUN) && (inputs_remaining!=0) && (!out_valid || out_ready). It is combinational from state and out_ready.
- Beat: in_valid && in_ready. On a beat the block registers:
  - out_sum <= in_a + (op_sub ? ~in_b : in_b) + carry, truncated to WORD_WIDTH.
  - carry <= bit WORD_WIDTH of that sum.
  - out_valid <= 1.
  - out_last <= (inputs_remaining==1).
  - inputs_remaining is decremented.
- Latency: a result word appears one cycle after its input beat. Throughput is one word per cycle when out_ready is held high.
- Backpressure: while out_valid && !out_ready, out_sum and out_last hold stable and in_ready=0.
- out_valid clears on an output handshake that has no simultaneous input beat.
- RUN -> DONE: on the output handshake of the word with out_last=1. In that same edge carry_out <= carry.
- DONE: done=1 for exactly one cycle, then the block returns to IDLE.
- carry_out holds its value until the next accepted start. At that start it is not cleared; it updates at the next completion.
- The output stream never contains more or fewer than num_words words per command.
- rst mid-operation: the partial result is discarded. out_valid drops on the next edge and no done pulse is issued.

Test Plan (WORD_WIDTH=8, LEN_WIDTH=8):
- Add with carry chaining: num_words=2, op_sub=0, pairs (A,B) = (FF,01), (01,00) -> out_sum 00 then 02; out_last=1 on the second word; carry_out=0; done pulses one cycle after the second output handshake.
- Subtract: op_sub=1, num_words=2, pairs (00,01), (01,00) -> out_sum FF then 00; carry_out=1 (0x0100-0x0001=0x00FF, no borrow). Also 0x0001-0x0002 -> FF, FF with carry_out=0.
- Overflow and throughput: num_words=4, all A=FF, B=00 except B0=01, in_valid and out_ready held at 1 -> four outputs 00, 00, 00, 00 on consecutive cycles; carry_out=1; busy high for 6 cycles.
- Backpressure: same stimulus as the first test, with out_ready=0 for 3 cycles after the first output -> out_sum stays 00, in_ready=0 during the stall, final results unchanged.
- Command rules: start with num_words=0 -> busy stays 0 and no done; start pulsed during RUN -> no effect on word count or results.
- Reset mid-op: rst asserted after the first of 3 beats -> next cycle busy=0 and out_valid=0; a new 1-word add (10+20) then yields 30 with carry_out=0.

Source files
------------

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer: streams word pairs LSW-first through one
// carry-lookahead adder stage, chaining the inter-word carry in a register.
module mp_add_sequencer #(
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  op_sub,
   input  logic [LEN_WIDTH-1:0]  num_words,
   output logic                  busy,
   output logic                  done,
   output logic                  carry_out,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WORD_WIDTH-1:0] in_a,
   input  logic [WORD_WIDTH-1:0] in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORD_WIDTH-1:0] out_sum,
   output logic                  out_last
);

   localparam int unsigned NGRP = (WORD_WIDTH + 3) / 4;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state;
   logic                 op_sub_q;
   logic                 carry_q;
   logic [LEN_WIDTH-1:0] remaining;

   logic [WORD_WIDTH-1:0] b_eff;
   logic [WORD_WIDTH-1:0] gen;
   logic [WORD_WIDTH-1:0] prop;
   logic [WORD_WIDTH-1:0] sum;
   logic [WORD_WIDTH:0]   c;
   logic [NGRP-1:0]       grp_g;
   logic [NGRP-1:0]       grp_p;
   logic [NGRP:0]         grp_c;

   logic beat;
   logic out_hs;

   // Two-level lookahead: 4-bit group generate/propagate feed the group carries,
   // bit carries inside a group start from that group's lookahead carry.
   always_comb begin
      b_eff = op_sub_q ? ~in_b : in_b;
      gen   = in_a & b_eff;
      prop  = in_a ^ b_eff;
      grp_g = '0;
      grp_p = '1;
      for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
         grp_g[i/4] = gen[i] | (prop[i] & grp_g[i/4]);
         grp_p[i/4] = grp_p[i/4] & prop[i];
      end
      grp_c    = '0;
      grp_c[0] = carry_q;
      for (int unsigned k = 0; k < NGRP; k++) begin
         grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
      end
      c    = '0;
      c[0] = grp_c[0];
      for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
         if (((i + 1) % 4) == 0) c[i+1] = grp_c[(i+1)/4];
         else                    c[i+1] = gen[i] | (prop[i] & c[i]);
      end
      sum = prop ^ c[WORD_WIDTH-1:0];
   end

   assign busy     = (state != IDLE);
   assign in_ready = (state == RUN) && (remaining != '0) && (!out_valid || out_ready);
   assign beat     = in_valid && in_ready;
   assign out_hs   = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op_sub_q  <= 1'b0;
         remaining <= '0;
         carry_q   <= 1'b0;
         carry_out <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_last  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && (num_words != '0)) begin
                  state     <= RUN;
                  op_sub_q  <= op_sub;
                  remaining <= num_words;
                  carry_q   <= op_sub;
               end
            end
            RUN: begin
               if (beat) begin
                  out_sum   <= sum;
                  carry_q   <= c[WORD_WIDTH];
                  out_valid <= 1'b1;
                  out_last  <= (remaining == LEN_WIDTH'(1));
                  remaining <= remaining - LEN_WIDTH'(1);
               end else if (out_hs) begin
                  out_valid <= 1'b0;
               end
               // No beat can coincide with the final handshake: the count is already zero.
               if (out_hs && out_last) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  carry_out <= carry_q;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Scoreboard bench for mp_add_sequencer: directed vectors push expected words,
// a negedge monitor pops and compares on every output handshake.
module tb_mp_add_sequencer;

   localparam int unsigned W = 8;
   localparam int unsigned L = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         op_sub;
   logic [L-1:0] num_words;
   logic         busy;
   logic         done;
   logic         carry_out;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_last;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         last;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last_hs_cyc = -100;
   int   bc, dn, ov;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   mp_add_sequencer #(.WORD_WIDTH(W), .LEN_WIDTH(L)) dut (
      .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .num_words(num_words),
      .busy(busy), .done(done), .carry_out(carry_out),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_last(out_last)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_word: got %0h with no word expected (t=%0t)", out_sum, $time);
         end else begin
            e = exp_q.pop_front();
            check("out_sum", {24'd0, out_sum}, {24'd0, e.sum});
            check("out_last", {31'd0, out_last}, {31'd0, e.last});
            if (out_last) last_hs_cyc = cyc;
         end
      end
   end

   task automatic do_start(input logic op, input logic [L-1:0] nw);
      @(posedge clk); #1;
      start = 1'b1; op_sub = op; num_words = nw;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic feed(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] es, input logic el, input logic push);
      int  n;
      logic hs;
      if (push) exp_q.push_back({es, el});
      in_a = a; in_b = b; in_valid = 1'b1;
      n = 0; hs = 1'b0;
      while (!hs && n < 50) begin
         @(negedge clk);
         hs = in_ready;
         @(posedge clk);
         n++;
      end
      #1;
      in_valid = 1'b0;
      if (!hs) begin
         checks++; failures++;
         $display("FAIL feed_timeout: got no beat for a=%0h b=%0h within 50 cycles", a, b);
      end
   endtask

   task automatic wait_done(input logic exp_carry, input logic chk_timing);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 50);
      if (!done) begin
         checks++; failures++;
         $display("FAIL done_timeout: got no done pulse within 50 cycles, expected one");
      end else begin
         if (chk_timing) check("done_timing", cyc, last_hs_cyc + 1);
         check("carry_out", {31'd0, carry_out}, {31'd0, exp_carry});
         @(negedge clk);
         check("done_width", {31'd0, done}, 32'd0);
         check("busy_after", {31'd0, busy}, 32'd0);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op_sub = 1'b0; num_words = '0;
      in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_carry_out", {31'd0, carry_out}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_sum", {24'd0, out_sum}, 32'd0);
      check("rst_out_last", {31'd0, out_last}, 32'd0);

      // add with carry chaining: 0x01FF + 0x0001 = 0x0200
      do_start(1'b0, 8'd2);
      feed(8'hFF, 8'h01, 8'h00, 1'b0, 1'b1);
      feed(8'h01, 8'h00, 8'h02, 1'b1, 1'b1);
      wait_done(1'b0, 1'b1);

      // 0x0100 - 0x0001 = 0x00FF, no borrow
      do_start(1'b1, 8'd2);
      feed(8'h00, 8'h01, 8'hFF, 1'b0, 1'b1);
      feed(8'h01, 8'h00, 8'h00, 1'b1, 1'b1);
      wait_done(1'b1, 1'b1);

      // 0x0001 - 0x0002 = 0xFFFF, borrow
      do_start(1'b1, 8'd2);
      feed(8'h01, 8'h02, 8'hFF, 1'b0, 1'b1);
      feed(8'h00, 8'h00, 8'hFF, 1'b1, 1'b1);
      wait_done(1'b0, 1'b1);

      // 4-word overflow at full throughput
      do_start(1'b0, 8'd4);
      bc = 0; dn = 0; ov = 0;
      fork
         begin
            feed(8'hFF, 8'h01, 8'h00, 1'b0, 1'b1);
            feed(8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);
            feed(8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);
            feed(8'hFF, 8'h00, 8'h00, 1'b1, 1'b1);
         end
         begin
            for (int i = 0; i < 14; i++) begin
               @(negedge clk);
               if (busy) bc++;
               if (done) dn++;
               if (out_valid) ov++;
            end
         end
      join
      check("busy_cycles", bc, 6);
      check("done_pulses", dn, 1);
      check("out_valid_cycles", ov, 4);
      check("carry_out_overflow", {31'd0, carry_out}, 32'd1);

      // zero-length command is ignored
      do_start(1'b0, 8'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("zero_len_busy", {31'd0, busy}, 32'd0);
         check("zero_len_done", {31'd0, done}, 32'd0);
      end
      check("zero_len_carry_hold", {31'd0, carry_out}, 32'd1);

      // backpressure: 3-cycle stall after the first output word
      out_ready = 1'b0;
      do_start(1'b0, 8'd2);
      check("carry_hold_at_start", {31'd0, carry_out}, 32'd1);
      fork
         begin
            feed(8'hFF, 8'h01, 8'h00, 1'b0, 1'b1);
            feed(8'h01, 8'h00, 8'h02, 1'b1, 1'b1);
         end
         begin
            int n;
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!out_valid && n < 50);
            for (int i = 0; i < 3; i++) begin
               check("stall_out_valid", {31'd0, out_valid}, 32'd1);
               check("stall_out_sum", {24'd0, out_sum}, 32'd0);
               check("stall_in_ready", {31'd0, in_ready}, 32'd0);
               @(posedge clk); #1;
               if (i < 2) @(negedge clk);
            end
            out_ready = 1'b1;
         end
      join
      wait_done(1'b0, 1'b1);

      // start pulsed during RUN with other length/op must not disturb the command
      do_start(1'b0, 8'd2);
      feed(8'h10, 8'h20, 8'h30, 1'b0, 1'b1);
      start = 1'b1; op_sub = 1'b1; num_words = 8'd5;
      feed(8'h30, 8'h40, 8'h70, 1'b1, 1'b1);
      start = 1'b0; op_sub = 1'b0;
      wait_done(1'b0, 1'b1);

      // reset after the first of three beats
      out_ready = 1'b0;
      do_start(1'b0, 8'd3);
      feed(8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
      @(negedge clk);
      check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("post_rst_done", {31'd0, done}, 32'd0);
      out_ready = 1'b1;
      do_start(1'b0, 8'd1);
      feed(8'h10, 8'h20, 8'h30, 1'b1, 1'b1);
      wait_done(1'b0, 1'b1);

      repeat (3) @(negedge clk);
      check("words_outstanding", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
